// File: rtl/part1_core.sv
// rtl/part1_core.sv - 16-bit five-stage in-order MIPS-like core with exported pipeline debug signals
// No forwarding or hazard interlock: software spaces dependent instructions with NOPs.
module part1_core #(
  parameter string IMEM_FILE0 = "imem0.hex",
  parameter string IMEM_FILE1 = "imem1.hex"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fileid,
  output logic [15:0] PCOUT,
  output logic [15:0] INST,
  output logic [3:0]  raddr1,
  output logic [3:0]  raddr2,
  output logic [15:0] rdata1,
  output logic [15:0] rdata2,
  output logic [15:0] rdata1_out_ID_EXE,
  output logic [15:0] rdata2_out_ID_EXE,
  output logic [15:0] imm_out_ID_EXE,
  output logic [15:0] rdata2_imm_out_ID_EXE,
  output logic [2:0]  aluop_out_ID_EXE,
  output logic        alusrc,
  output logic [3:0]  waddr_out_ID_EXE,
  output logic [3:0]  waddr_out_EXE_MEM,
  output logic [3:0]  waddr_out_MEM_WB,
  output logic [15:0] aluout,
  output logic [15:0] aluout_out_EXE_MEM,
  output logic [15:0] rdata2_out_EXE_MEM,
  output logic [15:0] dmrdata,
  output logic [15:0] aluout_out_MEM_WB
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0100;
  localparam logic [3:0] OP_ADDI = 4'b0101;
  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1001;

  typedef logic [15:0] rom_t [256];

  rom_t        imem0 = '{default: '0};
  rom_t        imem1 = '{default: '0};
  logic [15:0] dmem [256] = '{default: '0};
  logic [15:0] rf_q [16];

  // IF stage
  logic [15:0] pc_q, pc_d, inst_q, inst_d;

  // ID/EXE pipeline registers
  logic [15:0] rd1_ie_q, rd2_ie_q, imm_ie_q, imm_d;
  logic [2:0]  aluop_ie_q, aluop_d;
  logic        alusrc_ie_q, alusrc_d;
  logic [3:0]  waddr_ie_q, waddr_d;
  logic        memrd_ie_q, memrd_d, memwr_ie_q, memwr_d;

  // EXE/MEM and MEM/WB pipeline registers
  logic [15:0] alu_em_q, rd2_em_q;
  logic [3:0]  waddr_em_q;
  logic        memrd_em_q, memwr_em_q;
  logic [15:0] alu_mw_q, alu_mw_d;
  logic [3:0]  waddr_mw_q;

  logic [3:0]  opcode, rd, rs, rt;
  logic [15:0] alu_b;
  logic        wb_we;

  assign pc_d   = pc_q + 16'd1;
  assign inst_d = fileid ? imem1[pc_q[7:0]] : imem0[pc_q[7:0]];

  assign opcode = inst_q[15:12];
  assign rd     = inst_q[11:8];
  assign rs     = inst_q[7:4];
  assign rt     = inst_q[3:0];
  assign imm_d  = {{12{inst_q[3]}}, inst_q[3:0]};

  assign raddr1 = rs;
  assign raddr2 = (opcode == OP_SW) ? rd : rt;

  // A zero destination doubles as "no register write", so R0 is never written.
  assign wb_we  = (waddr_mw_q != 4'd0);
  assign rdata1 = (raddr1 == 4'd0) ? 16'd0 :
                  (wb_we && waddr_mw_q == raddr1) ? alu_mw_q : rf_q[raddr1];
  assign rdata2 = (raddr2 == 4'd0) ? 16'd0 :
                  (wb_we && waddr_mw_q == raddr2) ? alu_mw_q : rf_q[raddr2];

  always_comb begin
    aluop_d  = 3'b000;
    alusrc_d = 1'b0;
    waddr_d  = 4'd0;
    memrd_d  = 1'b0;
    memwr_d  = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: begin
        aluop_d = opcode[2:0];
        waddr_d = rd;
      end
      OP_ADDI: begin
        alusrc_d = 1'b1;
        waddr_d  = rd;
      end
      OP_LW: begin
        alusrc_d = 1'b1;
        waddr_d  = rd;
        memrd_d  = 1'b1;
      end
      OP_SW: begin
        alusrc_d = 1'b1;
        memwr_d  = 1'b1;
      end
      default: ;
    endcase
  end

  assign alu_b = alusrc_ie_q ? imm_ie_q : rd2_ie_q;

  always_comb begin
    aluout = 16'd0;
    case (aluop_ie_q)
      3'b000:  aluout = rd1_ie_q + alu_b;
      3'b001:  aluout = rd1_ie_q - alu_b;
      3'b010:  aluout = rd1_ie_q & alu_b;
      3'b011:  aluout = rd1_ie_q | alu_b;
      3'b100:  aluout = {15'd0, $signed(rd1_ie_q) < $signed(alu_b)};
      default: aluout = 16'd0;
    endcase
  end

  assign dmrdata  = dmem[alu_em_q[7:0]];
  assign alu_mw_d = memrd_em_q ? dmrdata : alu_em_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= '0;
      inst_q      <= '0;
      rd1_ie_q    <= '0;
      rd2_ie_q    <= '0;
      imm_ie_q    <= '0;
      aluop_ie_q  <= '0;
      alusrc_ie_q <= 1'b0;
      waddr_ie_q  <= '0;
      memrd_ie_q  <= 1'b0;
      memwr_ie_q  <= 1'b0;
      alu_em_q    <= '0;
      rd2_em_q    <= '0;
      waddr_em_q  <= '0;
      memrd_em_q  <= 1'b0;
      memwr_em_q  <= 1'b0;
      alu_mw_q    <= '0;
      waddr_mw_q  <= '0;
    end else begin
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      rd1_ie_q    <= rdata1;
      rd2_ie_q    <= rdata2;
      imm_ie_q    <= imm_d;
      aluop_ie_q  <= aluop_d;
      alusrc_ie_q <= alusrc_d;
      waddr_ie_q  <= waddr_d;
      memrd_ie_q  <= memrd_d;
      memwr_ie_q  <= memwr_d;
      alu_em_q    <= aluout;
      rd2_em_q    <= rd2_ie_q;
      waddr_em_q  <= waddr_ie_q;
      memrd_em_q  <= memrd_ie_q;
      memwr_em_q  <= memwr_ie_q;
      alu_mw_q    <= alu_mw_d;
      waddr_mw_q  <= waddr_em_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
    end else if (wb_we) begin
      rf_q[waddr_mw_q] <= alu_mw_q;
    end
  end

  // Data memory keeps its contents across reset; only the store is suppressed.
  always_ff @(posedge clk) begin
    if (!rst && memwr_em_q) dmem[alu_em_q[7:0]] <= rd2_em_q;
  end

  assign PCOUT                 = pc_q;
  assign INST                  = inst_q;
  assign rdata1_out_ID_EXE     = rd1_ie_q;
  assign rdata2_out_ID_EXE     = rd2_ie_q;
  assign imm_out_ID_EXE        = imm_ie_q;
  assign rdata2_imm_out_ID_EXE = alu_b;
  assign aluop_out_ID_EXE      = aluop_ie_q;
  assign alusrc                = alusrc_ie_q;
  assign waddr_out_ID_EXE      = waddr_ie_q;
  assign waddr_out_EXE_MEM     = waddr_em_q;
  assign waddr_out_MEM_WB      = waddr_mw_q;
  assign aluout_out_EXE_MEM    = alu_em_q;
  assign rdata2_out_EXE_MEM    = rd2_em_q;
  assign aluout_out_MEM_WB     = alu_mw_q;

endmodule

// File: tb/tb_part1_core.sv
// tb/tb_part1_core.sv - directed bench for part1_core
// Programs are poked into the ROM images; cycle k is the cycle in which PCOUT == k.
module tb_part1_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        fileid;
  logic [15:0] PCOUT, INST, rdata1, rdata2;
  logic [3:0]  raddr1, raddr2;
  logic [15:0] rdata1_out_ID_EXE, rdata2_out_ID_EXE, imm_out_ID_EXE, rdata2_imm_out_ID_EXE;
  logic [2:0]  aluop_out_ID_EXE;
  logic        alusrc;
  logic [3:0]  waddr_out_ID_EXE, waddr_out_EXE_MEM, waddr_out_MEM_WB;
  logic [15:0] aluout, aluout_out_EXE_MEM, rdata2_out_EXE_MEM, dmrdata, aluout_out_MEM_WB;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] prog0 [20] = '{
    16'h5105, 16'h5203, 16'hF000, 16'hF000, 16'h0312,
    16'h1512, 16'h2612, 16'h3712, 16'h4812, 16'h4921,
    16'h550F, 16'h5005, 16'h9302, 16'hF000, 16'hF000,
    16'h8402, 16'h0D00, 16'hF000, 16'h0E40, 16'h0F14
  };
  logic [15:0] prog1 [4] = '{16'h0012, 16'h0021, 16'hF0A5, 16'h6789};

  part1_core #(.IMEM_FILE0(""), .IMEM_FILE1("")) dut (
    .clk(clk), .rst(rst), .fileid(fileid),
    .PCOUT(PCOUT), .INST(INST),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .rdata1_out_ID_EXE(rdata1_out_ID_EXE), .rdata2_out_ID_EXE(rdata2_out_ID_EXE),
    .imm_out_ID_EXE(imm_out_ID_EXE), .rdata2_imm_out_ID_EXE(rdata2_imm_out_ID_EXE),
    .aluop_out_ID_EXE(aluop_out_ID_EXE), .alusrc(alusrc),
    .waddr_out_ID_EXE(waddr_out_ID_EXE), .waddr_out_EXE_MEM(waddr_out_EXE_MEM),
    .waddr_out_MEM_WB(waddr_out_MEM_WB), .aluout(aluout),
    .aluout_out_EXE_MEM(aluout_out_EXE_MEM), .rdata2_out_EXE_MEM(rdata2_out_EXE_MEM),
    .dmrdata(dmrdata), .aluout_out_MEM_WB(aluout_out_MEM_WB)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_pipe(input string tag);
    chk({tag, "_pc"}, PCOUT, 16'h0);
    chk({tag, "_inst"}, INST, 16'h0);
    chk({tag, "_rd1_ie"}, rdata1_out_ID_EXE, 16'h0);
    chk({tag, "_rd2_ie"}, rdata2_out_ID_EXE, 16'h0);
    chk({tag, "_imm_ie"}, imm_out_ID_EXE, 16'h0);
    chk({tag, "_aluop"}, {13'd0, aluop_out_ID_EXE}, 16'h0);
    chk({tag, "_alusrc"}, {15'd0, alusrc}, 16'h0);
    chk({tag, "_wa_ie"}, {12'd0, waddr_out_ID_EXE}, 16'h0);
    chk({tag, "_wa_em"}, {12'd0, waddr_out_EXE_MEM}, 16'h0);
    chk({tag, "_wa_mw"}, {12'd0, waddr_out_MEM_WB}, 16'h0);
    chk({tag, "_alu_em"}, aluout_out_EXE_MEM, 16'h0);
    chk({tag, "_rd2_em"}, rdata2_out_EXE_MEM, 16'h0);
    chk({tag, "_alu_mw"}, aluout_out_MEM_WB, 16'h0);
  endtask

  initial begin
    rst = 1'b1;
    fileid = 1'b0;
    #1;
    for (int i = 0; i < 20; i++) dut.imem0[i] = prog0[i];
    for (int i = 0; i < 4; i++) dut.imem1[i] = prog1[i];

    tick(); tick();
    chk_zero_pipe("por");
    rst = 1'b0;

    tick(); // c1
    chk("c1_pc", PCOUT, 16'd1);
    chk("c1_inst", INST, 16'h5105);
    tick(); // c2: ADDI r1 in EXE
    chk("c2_inst", INST, 16'h5203);
    chk("c2_alusrc", {15'd0, alusrc}, 16'd1);
    chk("c2_b_imm", rdata2_imm_out_ID_EXE, 16'd5);
    chk("c2_wa_ie", {12'd0, waddr_out_ID_EXE}, 16'd1);
    chk("c2_alu", aluout, 16'd5);
    tick(); // c3
    chk("c3_inst", INST, 16'hF000);
    tick(); // c4: ADDI r1 in WB
    chk("c4_wa_mw", {12'd0, waddr_out_MEM_WB}, 16'd1);
    chk("c4_alu_mw", aluout_out_MEM_WB, 16'd5);
    tick(); // c5: ADD in ID, r2 written back this cycle
    chk("c5_inst", INST, 16'h0312);
    chk("c5_raddr2", {12'd0, raddr2}, 16'd2);
    chk("c5_rdata1", rdata1, 16'd5);
    chk("c5_bypass_r2", rdata2, 16'd3);
    tick(); // c6
    chk("c6_add", aluout, 16'd8);
    chk("c6_alusrc", {15'd0, alusrc}, 16'd0);
    tick(); // c7
    chk("c7_sub", aluout, 16'd2);
    chk("c7_alu_em", aluout_out_EXE_MEM, 16'd8);
    tick(); // c8
    chk("c8_and", aluout, 16'd1);
    chk("c8_wa_mw", {12'd0, waddr_out_MEM_WB}, 16'd3);
    chk("c8_alu_mw", aluout_out_MEM_WB, 16'd8);
    tick(); // c9
    chk("c9_or", aluout, 16'd7);
    tick(); // c10
    chk("c10_slt_5_3", aluout, 16'd0);
    tick(); // c11
    chk("c11_slt_3_5", aluout, 16'd1);
    chk("c11_aluop", {13'd0, aluop_out_ID_EXE}, 16'd4);
    tick(); // c12
    chk("c12_addi_m1", aluout, 16'hFFFF);
    chk("c12_imm", imm_out_ID_EXE, 16'hFFFF);
    tick(); // c13: ADDI r0 in EXE, SW in ID
    chk("c13_addi_r0", aluout, 16'd5);
    chk("c13_wa_r0", {12'd0, waddr_out_ID_EXE}, 16'd0);
    chk("c13_sw_raddr2", {12'd0, raddr2}, 16'd3);
    chk("c13_sw_rdata2", rdata2, 16'd8);
    tick(); // c14
    chk("c14_sw_rd2_ie", rdata2_out_ID_EXE, 16'd8);
    chk("c14_sw_addr", aluout, 16'd2);
    chk("c14_sw_wa", {12'd0, waddr_out_ID_EXE}, 16'd0);
    tick(); // c15: ADDI r0 in WB
    chk("c15_r0_read", rdata1, 16'd0);
    chk("c15_wa_mw", {12'd0, waddr_out_MEM_WB}, 16'd0);
    chk("c15_rd2_em", rdata2_out_EXE_MEM, 16'd8);
    tick(); tick(); tick(); // c18: LW in MEM
    chk("c18_alu_em", aluout_out_EXE_MEM, 16'd2);
    chk("c18_dmrdata", dmrdata, 16'd8);
    tick(); // c19: LW in WB, ADD r14,r4 in ID
    chk("c19_wa_mw", {12'd0, waddr_out_MEM_WB}, 16'd4);
    chk("c19_alu_mw", aluout_out_MEM_WB, 16'd8);
    chk("c19_raddr1", {12'd0, raddr1}, 16'd4);
    chk("c19_bypass_r4", rdata1, 16'd8);
    tick(); // c20
    chk("c20_rdata1", rdata1, 16'd5);
    chk("c20_rdata2", rdata2, 16'd8);
    tick(); // c21
    chk("c21_add_r1_r4", aluout, 16'd13);
    tick(); tick(); tick(); // c24

    rst = 1'b1;
    tick();
    chk_zero_pipe("mid");
    rst = 1'b0;
    tick();
    chk("rst_pc1", PCOUT, 16'd1);
    tick();
    chk("rst_pc2", PCOUT, 16'd2);
    tick();
    chk("rst_pc3", PCOUT, 16'd3);

    fileid = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("f1_inst0", INST, 16'h0012);
    chk("f1_r1_cleared", rdata1, 16'd0);
    chk("f1_r2_cleared", rdata2, 16'd0);
    tick();
    chk("f1_inst1", INST, 16'h0021);
    tick();
    chk("f1_inst2", INST, 16'hF0A5);
    tick();
    chk("f1_inst3", INST, 16'h6789);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
